alu_accumulator_ctrl: RTL and testbench
=======================================

# alu_accumulator_ctrl

Sequential front/back-end for the team's 4-bit combinational ALU (add / subtract / compare / AND, 2-bit select). It accepts one command per transaction over a valid/ready handshake and registers the ALU select and operand inputs, with operand A always taken from an internal accumulator. After one settle cycle it captures the ALU outputs into the accumulator and flag registers, then presents a result over a second valid/ready handshake. The block sits directly upstream and downstream of the ALU: it drives the ALU's inputs and consumes its outputs.

## Interface
- `WIDTH`, 4: datapath width; fixed to the ALU width. Other values are unsupported.
- `ACC_INIT`, 4'h0: accumulator value after reset.

- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: 00 add, 01 sub, 10 compare, 11 AND.
- `cmd_load` in 1: 1 loads `cmd_b` into the accumulator; `cmd_op` is ignored.
- `cmd_b` in 4: operand B.
- `alu_s0`, `alu_s1` out 1 each: registered ALU select, where {s1,s0} = op.
- `alu_a`, `alu_b` out 4 each: registered ALU operands.
- `alu_sas` in 4, `alu_cas` in 1: ALU sum/difference and carry-out.
- `alu_and` in 4: ALU AND result.
- `alu_agtb`, `alu_aeqb`, `alu_bgta` in 1 each: ALU comparator outputs.
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 4: result value.
- `res_carry` out 1: captured carry.
- `res_flags` out 3: {gt, eq, lt}, where gt means acc > B.
- `acc` out 4: current accumulator value.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, register `alu_a`←acc, `alu_b`←`cmd_b`, {s1,s0}←`cmd_op`.
  - If `cmd_load`=0, go to EXEC. If `cmd_load`=1, set acc←`cmd_b` and `res_data`←`cmd_b`, set `res_carry`←0, leave flags unchanged, and go to RESP.
- EXEC (one cycle; ALU inputs stable and settled). Capture at the end of the cycle:
  - op 00 and 01: `res_data`=acc←`alu_sas`; `res_carry`←`alu_cas`. For sub, carry=1 means A≥B (no borrow).
  - op 11: `res_data`=acc←`alu_and`; `res_carry`←0.
  - op 10: acc is unchanged; `res_data`←acc; `res_carry`←0; flags←{`alu_agtb`,`alu_aeqb`,`alu_bgta`}.
  - Flags update only on op 10. The ALU's gated comparator reports eq=1 for every other op, so those values are never captured.
  - Go to RESP.
- RESP:
  - `res_valid`=1 and `cmd_ready`=0.
  - `res_data`, `res_carry` and `res_flags` hold stable until `res_valid`&&`res_ready`; then go to IDLE.
- Arithmetic wraps modulo 16; carry-out is reported, never saturated.
- ALU drive registers hold their last values outside IDLE acceptance.

## Timing
- Reset values:
  - state IDLE, acc=`ACC_INIT`.
  - `cmd_ready`=1 once out of reset (it is 0 while `rst` is high).
  - `res_valid`=0, `res_data`=0, `res_carry`=0, `res_flags`=3'b000.
  - `alu_s0`=`alu_s1`=0, `alu_a`=`alu_b`=0.
- Latency for ALU ops: accept at edge N, EXEC during cycle N+1, `res_valid` high from cycle N+2.
- Latency for load: `res_valid` high from cycle N+1.
- Throughput with `res_ready` held high: one ALU op per 3 cycles, one load per 2 cycles.
- `res_ready` low: RESP holds indefinitely and no new command is accepted (backpressure).
- `cmd_valid` during EXEC or RESP: ignored (`cmd_ready`=0); the command is not consumed.
- `rst` in any state: all registers return to reset values on the next edge. An in-flight command is dropped and produces no result.
- `rst` and `cmd_valid` in the same cycle: reset wins; the command is not accepted.

## Structure
- Shared package holds:
  - the op encoding constants `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_CMP`=2'b10, `OP_AND`=2'b11;
  - the FSM state enum;
  - the flag bit indices `FLAG_GT`=2, `FLAG_EQ`=1, `FLAG_LT`=0.
- No sub-module in this block. The ALU is instantiated beside it at the level above and wired through the `alu_*` ports.
- The bench instantiates both together as `alu_accumulator_top`.

## Test plan
- Reset, then a load of B=5 → `res_valid` at cycle +1 with `res_data`=5 and acc=5. Then add B=4 → `res_data`=9, carry=0, `res_valid` at +2.
- acc=12, add B=7 → `res_data`=3 and `res_carry`=1 (wrap); acc=3.
- acc=3, sub B=5 → `res_data`=14, carry=0 (borrow). Then load 9, sub B=9 → `res_data`=0, carry=1.
- acc=6, compare B=6 → flags=3'b010 and acc stays 6. Compare B=9 → flags=3'b001. Then AND B=4'b0101 → `res_data`=4, and flags remain 3'b001.
- Hold `res_ready`=0 for 5 cycles in RESP while `cmd_valid`=1 → outputs stable, `cmd_ready`=0, no command consumed. Release → handshake completes and the next command is accepted in IDLE.
- Assert `rst` during EXEC → no `res_valid`, acc=`ACC_INIT`, `cmd_ready`=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_accumulator_ctrl_pkg.sv
// Shared definitions for the ALU accumulator controller: op encoding,
// FSM states and result-flag bit positions.
package alu_accumulator_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_accumulator_ctrl.sv
// Sequential wrapper around an external 4-bit combinational ALU: accepts a
// command, drives the ALU from registers, captures its outputs, returns a result.
module alu_accumulator_ctrl
  import alu_accumulator_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = 4'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_sas,
  input  logic             alu_cas,
  input  logic [WIDTH-1:0] alu_and,
  input  logic             alu_agtb,
  input  logic             alu_aeqb,
  input  logic             alu_bgta,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic [2:0]       res_flags,
  output logic [WIDTH-1:0] acc
);

  state_t     state;
  logic [1:0] alu_op;
  logic       ready_q;

  assign {alu_s1, alu_s0} = alu_op;
  // Masked by rst so an upstream sender never sees ready while reset is held.
  assign cmd_ready = ready_q & ~rst;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= ACC_INIT;
      ready_q   <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_flags <= 3'b000;
      alu_op    <= 2'b00;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a   <= acc;
            alu_b   <= cmd_b;
            alu_op  <= cmd_op;
            ready_q <= 1'b0;
            if (cmd_load) begin
              acc       <= cmd_b;
              res_data  <= cmd_b;
              res_carry <= 1'b0;
              res_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          // The ALU has had a full cycle to settle on the registered inputs.
          case (alu_op)
            OP_ADD, OP_SUB: begin
              acc       <= alu_sas;
              res_data  <= alu_sas;
              res_carry <= alu_cas;
            end
            OP_CMP: begin
              res_data           <= acc;
              res_carry          <= 1'b0;
              res_flags[FLAG_GT] <= alu_agtb;
              res_flags[FLAG_EQ] <= alu_aeqb;
              res_flags[FLAG_LT] <= alu_bgta;
            end
            default: begin
              acc       <= alu_and;
              res_data  <= alu_and;
              res_carry <= 1'b0;
            end
          endcase
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ready_q   <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          res_valid <= 1'b0;
          ready_q   <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_accumulator_ctrl.sv
// Bench for alu_accumulator_ctrl wired to a behavioural 4-bit ALU; directed
// table, handshake corner cases, then random commands against a reference model.
module tb_alu_accumulator_ctrl;
  import alu_accumulator_ctrl_pkg::*;

  localparam logic [3:0] ACC_INIT = 4'h0;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [1:0] cmd_op;
  logic [3:0] cmd_b;
  logic       alu_s0, alu_s1;
  logic [3:0] alu_a, alu_b, alu_sas, alu_and;
  logic       alu_cas, alu_agtb, alu_aeqb, alu_bgta;
  logic       res_valid, res_ready, res_carry;
  logic [3:0] res_data, acc;
  logic [2:0] res_flags;

  int total = 0;
  int bad   = 0;

  logic [3:0] acc_m;
  logic [2:0] flags_m;

  always #5 clk = ~clk;

  // alu_accumulator_top: controller plus the ALU it drives.
  alu_accumulator_ctrl #(.WIDTH(4), .ACC_INIT(ACC_INIT)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_load(cmd_load), .cmd_b(cmd_b),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sas(alu_sas), .alu_cas(alu_cas), .alu_and(alu_and),
    .alu_agtb(alu_agtb), .alu_aeqb(alu_aeqb), .alu_bgta(alu_bgta),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_flags(res_flags), .acc(acc)
  );

  // Combinational ALU: adder/subtractor via two's complement, gated comparator.
  always_comb begin
    {alu_cas, alu_sas} = alu_s0 ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1)
                                : ({1'b0, alu_a} + {1'b0, alu_b});
    alu_and  = alu_a & alu_b;
    alu_agtb = 1'b0;
    alu_aeqb = 1'b1;
    alu_bgta = 1'b0;
    if ({alu_s1, alu_s0} == OP_CMP) begin
      alu_agtb = alu_a > alu_b;
      alu_aeqb = alu_a == alu_b;
      alu_bgta = alu_b > alu_a;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and check the whole transaction.
  task automatic run_cmd(input logic ld, input logic [1:0] op, input logic [3:0] b,
                         input logic [3:0] exp_data, input logic exp_carry,
                         input logic [2:0] exp_flags, input logic [3:0] exp_acc,
                         input int hold);
    int         cyc;
    logic [3:0] acc_before;
    acc_before = acc_m;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_b     = b;
    res_ready = (hold == 0);
    step();
    cmd_valid = 1'b0;
    check("alu_a", alu_a, acc_before);
    check("alu_b", alu_b, b);
    check("alu_sel", {alu_s1, alu_s0}, op);
    cyc = 1;
    while (!res_valid && cyc < 8) begin
      step();
      cyc++;
    end
    check("latency", cyc, ld ? 1 : 2);
    check("cmd_ready_busy", cmd_ready, 0);
    if (hold > 0) begin
      repeat (hold) step();
      check("held_valid", res_valid, 1);
      res_ready = 1'b1;
    end
    check("res_data", res_data, exp_data);
    check("res_carry", res_carry, exp_carry);
    check("res_flags", res_flags, exp_flags);
    check("acc", acc, exp_acc);
    step();
    check("valid_drop", res_valid, 0);
    acc_m   = exp_acc;
    flags_m = exp_flags;
  endtask

  typedef struct {
    logic       ld;
    logic [1:0] op;
    logic [3:0] b;
    logic [3:0] data;
    logic       carry;
    logic [2:0] flags;
    logic [3:0] acc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [4:0] sum;
    logic [3:0] e_data, e_acc;
    logic       e_carry, ld;
    logic [2:0] e_flags;
    logic [1:0] op;
    logic [3:0] b;

    vecs[0]  = '{1'b1, OP_ADD, 4'd5,  4'd5,  1'b0, 3'b000, 4'd5};
    vecs[1]  = '{1'b0, OP_ADD, 4'd4,  4'd9,  1'b0, 3'b000, 4'd9};
    vecs[2]  = '{1'b1, OP_ADD, 4'd12, 4'd12, 1'b0, 3'b000, 4'd12};
    vecs[3]  = '{1'b0, OP_ADD, 4'd7,  4'd3,  1'b1, 3'b000, 4'd3};
    vecs[4]  = '{1'b0, OP_SUB, 4'd5,  4'd14, 1'b0, 3'b000, 4'd14};
    vecs[5]  = '{1'b1, OP_ADD, 4'd9,  4'd9,  1'b0, 3'b000, 4'd9};
    vecs[6]  = '{1'b0, OP_SUB, 4'd9,  4'd0,  1'b1, 3'b000, 4'd0};
    vecs[7]  = '{1'b1, OP_CMP, 4'd6,  4'd6,  1'b0, 3'b000, 4'd6};
    vecs[8]  = '{1'b0, OP_CMP, 4'd6,  4'd6,  1'b0, 3'b010, 4'd6};
    vecs[9]  = '{1'b0, OP_CMP, 4'd9,  4'd6,  1'b0, 3'b001, 4'd6};
    vecs[10] = '{1'b0, OP_AND, 4'd5,  4'd4,  1'b0, 3'b001, 4'd4};
    vecs[11] = '{1'b1, OP_SUB, 4'd15, 4'd15, 1'b0, 3'b001, 4'd15};

    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 2'b00; cmd_b = 4'd0;
    res_ready = 1'b1;
    acc_m = ACC_INIT; flags_m = 3'b000;
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_res_valid", res_valid, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("rst_res_data", res_data, 0);
    check("rst_res_carry", res_carry, 0);
    check("rst_res_flags", res_flags, 0);
    check("rst_alu_drive", {alu_s1, alu_s0, alu_a, alu_b}, 0);
    check("rst_acc", acc, ACC_INIT);

    for (int i = 0; i < 12; i++)
      run_cmd(vecs[i].ld, vecs[i].op, vecs[i].b, vecs[i].data, vecs[i].carry,
              vecs[i].flags, vecs[i].acc, 0);

    // Backpressure: result held 5 cycles while a new command waits.
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD; cmd_b = 4'd2;
    res_ready = 1'b0;
    step();
    cmd_load = 1'b1; cmd_b = 4'd7;
    step();
    check("bp_valid", res_valid, 1);
    check("bp_data", res_data, 4'd1);
    check("bp_carry", res_carry, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_ready", cmd_ready, 0);
      check("bp_hold_data", {res_data, res_carry, res_flags}, {4'd1, 1'b1, 3'b001});
      check("bp_hold_acc", acc, 4'd1);
    end
    res_ready = 1'b1;
    step();
    check("bp_release_valid", res_valid, 0);
    check("bp_release_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    check("bp_next_valid", res_valid, 1);
    check("bp_next_data", res_data, 4'd7);
    check("bp_next_acc", acc, 4'd7);
    step();
    check("bp_next_done", res_valid, 0);
    acc_m = 4'd7;

    // Reset while the command is in EXEC.
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD; cmd_b = 4'd3;
    step();
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    check("exec_rst_ready", cmd_ready, 0);
    check("exec_rst_valid", res_valid, 0);
    rst = 1'b0;
    #1;
    check("exec_rst_ready_after", cmd_ready, 1);
    check("exec_rst_acc", acc, ACC_INIT);
    repeat (3) begin
      step();
      check("exec_rst_no_result", res_valid, 0);
    end

    // Reset and a command in the same cycle: the command is dropped.
    rst = 1'b1; cmd_valid = 1'b1; cmd_load = 1'b1; cmd_b = 4'd11;
    step();
    rst = 1'b0; cmd_valid = 1'b0;
    step();
    check("rst_cmd_dropped_valid", res_valid, 0);
    check("rst_cmd_dropped_acc", acc, ACC_INIT);
    acc_m = ACC_INIT; flags_m = 3'b000;

    // Random commands against the reference model.
    for (int i = 0; i < 60; i++) begin
      ld = ($urandom_range(0, 4) == 0);
      op = 2'($urandom_range(0, 3));
      b  = 4'($urandom_range(0, 15));
      e_flags = flags_m;
      e_carry = 1'b0;
      e_acc   = acc_m;
      if (ld) begin
        e_acc = b;
      end else if (op == OP_ADD) begin
        sum = acc_m + b;
        e_acc = sum[3:0];
        e_carry = sum[4];
      end else if (op == OP_SUB) begin
        e_carry = (acc_m >= b);
        e_acc = 4'((int'(acc_m) - int'(b) + 16) % 16);
      end else if (op == OP_AND) begin
        e_acc = acc_m & b;
      end else begin
        e_flags = {acc_m > b, acc_m == b, acc_m < b};
      end
      e_data = e_acc;
      run_cmd(ld, op, b, e_data, e_carry, e_flags, e_acc, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
